// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard sequencer:
//   - sequencer state encodings (INIT, RUN, MEM_WAIT, ERROR)
//   - REG_ZERO, the hard-wired zero register that never creates a hazard
//   - default performance-counter width
//   - pipe_ctrl_t, the bundle of pipeline enables/flushes, plus the fixed
//     control patterns the sequencer selects between
package hazard_ctrl_pkg;

    localparam logic [1:0] ST_INIT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_ERROR    = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int CNT_W_DEFAULT = 16;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_flush;
        logic exmem_write;
        logic memwb_flush;
    } pipe_ctrl_t;

    // Whole pipeline held and every register loaded with a bubble.
    localparam pipe_ctrl_t CTRL_BUBBLE = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_write: 1'b0,
        idex_flush: 1'b1, exmem_write: 1'b0, memwb_flush: 1'b1};

    // Data-memory wait: everything upstream of MEM holds, MEM/WB gets a bubble.
    localparam pipe_ctrl_t CTRL_FREEZE = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_write: 1'b0,
        idex_flush: 1'b0, exmem_write: 1'b0, memwb_flush: 1'b1};

    // Normal flow, every stage advances.
    localparam pipe_ctrl_t CTRL_FLOW = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_write: 1'b1,
        idex_flush: 1'b0, exmem_write: 1'b1, memwb_flush: 1'b0};

    // Taken branch in EX: squash both younger instructions in IF/ID and ID/EX.
    localparam pipe_ctrl_t CTRL_BRANCH = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_write: 1'b1,
        idex_flush: 1'b1, exmem_write: 1'b1, memwb_flush: 1'b0};

    // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
    localparam pipe_ctrl_t CTRL_LOAD_USE = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_write: 1'b1,
        idex_flush: 1'b1, exmem_write: 1'b1, memwb_flush: 1'b0};

    // Jump in ID: only the instruction fetched behind it is squashed.
    localparam pipe_ctrl_t CTRL_JUMP = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_write: 1'b1,
        idex_flush: 1'b0, exmem_write: 1'b1, memwb_flush: 1'b0};

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter
// Saturating up-counter used for the hazard performance counters.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high clear
//   inc   - count one event this cycle
//   count - current value, sticks at all-ones instead of wrapping
module sat_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Increment only while below the all-ones ceiling so long runs of
    // stalls never roll the statistic back to a small number.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline sequencer for the 5-stage MIPS datapath. Turns decoded hazard
// information into PC / pipeline-register write enables and bubble controls.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt - source registers of the instruction in ID
//   id_jump                  - ID instruction is J/JAL/JR
//   ex_memRead, ex_rt        - EX instruction is a load and its destination
//   ex_branch_taken          - EX branch resolved taken
//   mem_req, mem_ready       - MEM-stage data access and its completion
//   pc_write .. memwb_flush  - pipeline enables / bubble controls (Mealy)
//   mem_timeout              - sticky flag: data memory never answered
//   stall_cnt, flush_cnt     - saturating stall-cycle and squash counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 4,
    parameter int MAX_WAIT    = 15,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [INIT_W-1:0] INIT_LAST  = INIT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [INIT_W-1:0] init_cnt;
    logic [INIT_W-1:0] init_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic [WAIT_W-1:0] wait_inc;
    logic              freeze;
    logic              load_use;
    logic              stall_inc;
    logic              flush_inc;
    logic              timeout_set;
    pipe_ctrl_t        ctrl;

    assign freeze   = mem_req & ~mem_ready;
    assign wait_inc = wait_cnt + WAIT_W'(1);

    // A load in EX feeding a source of the ID instruction. Register 0 is
    // excluded because it reads as zero regardless of what is written.
    assign load_use = ex_memRead && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // Next-state and Mealy output decode. A memory freeze dominates every
    // other hazard: the EX/ID instructions stay put and are re-evaluated on
    // the cycle the freeze drops. Reset forces the all-bubble pattern no
    // matter which state the sequencer happens to be in.
    always_comb begin
        ctrl        = CTRL_BUBBLE;
        state_nxt   = state;
        init_nxt    = init_cnt;
        wait_nxt    = wait_cnt;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        timeout_set = 1'b0;

        case (state)
            ST_INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    init_nxt = init_cnt + INIT_W'(1);
                end
            end

            ST_RUN, ST_MEM_WAIT: begin
                if (freeze) begin
                    ctrl      = CTRL_FREEZE;
                    stall_inc = 1'b1;
                    wait_nxt  = (state == ST_RUN) ? WAIT_W'(1) : wait_inc;
                    if (wait_nxt >= WAIT_LIMIT) begin
                        state_nxt   = ST_ERROR;
                        timeout_set = 1'b1;
                    end else begin
                        state_nxt = ST_MEM_WAIT;
                    end
                end else begin
                    state_nxt = ST_RUN;
                    wait_nxt  = '0;
                    if (ex_branch_taken) begin
                        ctrl      = CTRL_BRANCH;
                        flush_inc = 1'b1;
                    end else if (load_use) begin
                        ctrl      = CTRL_LOAD_USE;
                        stall_inc = 1'b1;
                    end else if (id_jump) begin
                        ctrl      = CTRL_JUMP;
                        flush_inc = 1'b1;
                    end else begin
                        ctrl = CTRL_FLOW;
                    end
                end
            end

            ST_ERROR: begin
                ctrl = CTRL_BUBBLE;
            end

            default: begin
                state_nxt = ST_ERROR;
            end
        endcase

        if (rst) begin
            ctrl      = CTRL_BUBBLE;
            stall_inc = 1'b0;
            flush_inc = 1'b0;
        end
    end

    // Sequencer registers. mem_timeout is sticky: once set it stays set
    // until the next reset, as does the ERROR state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_nxt;
            wait_cnt <= wait_nxt;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_write  = ctrl.idex_write;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_write = ctrl.exmem_write;
    assign memwb_flush = ctrl.memwb_flush;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencer for the 5-stage MIPS datapath. Generates PC / pipeline-register write enables and flush (bubble) controls from decoded hazard information. Covers load-use stalls, branch/jump squashes and data-memory wait-state freezes. Also provides reset-time pipeline fill, a memory-wait timeout, and saturating performance counters. Sits beside the main decoder and consumes its EX/ID-stage control bits.

Parameters:
INIT_CYCLES, 4, cycles after reset during which PC is held and all stages are bubbled
MAX_WAIT, 15, maximum consecutive mem_ready-low cycles before timeout
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
id_jump  in  1  ID instruction is J/JAL/JR
ex_memRead  in  1  EX instruction is a load
ex_rt  in  5  destination rt of the EX instruction
ex_branch_taken  in  1  EX branch resolved taken
mem_req  in  1  MEM stage is performing a data access
mem_ready  in  1  data memory completes this cycle
pc_write  out  1  PC register load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID load bubble
idex_write  out  1  ID/EX load enable
idex_flush  out  1  ID/EX load bubble
exmem_write  out  1  EX/MEM load enable
memwb_flush  out  1  MEM/WB load bubble
mem_timeout  out  1  sticky memory-timeout error
stall_cnt  out  CNT_W  cycles lost to stalls/freezes
flush_cnt  out  CNT_W  branch/jump squash events

Behaviour:
- Single clock; rst is synchronous and active-high. All registered state updates on the rising clk edge.
- Control outputs are combinational from the current state and inputs (Mealy). Counters and mem_timeout are registered.
- States: INIT, RUN, MEM_WAIT, ERROR.
- Reset:
  - State goes to INIT; init counter, wait counter, stall_cnt, flush_cnt and mem_timeout are cleared to 0.
  - While rst=1, outputs are pc_write=0, ifid_write=0, idex_write=0, exmem_write=0, ifid_flush=1, idex_flush=1, memwb_flush=1.
- INIT:
  - Outputs are the same as during reset.
  - Stays in INIT for exactly INIT_CYCLES cycles after rst falls, then moves to RUN.
  - Counters do not increment.
- freeze = mem_req & ~mem_ready.
- RUN, when freeze=1:
  - pc_write=0, ifid_write=0, idex_write=0, exmem_write=0, memwb_flush=1; all other flushes are 0.
  - Next state MEM_WAIT; wait counter := 1; stall_cnt increments.
- RUN, when freeze=0, resolve in priority order (first match wins):
  1. ex_branch_taken: pc_write=1, ifid_flush=1, idex_flush=1; flush_cnt increments. Load-use and jump in the same cycle are ignored because those instructions are squashed.
  2. Load-use, i.e. ex_memRead & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)): pc_write=0, ifid_write=0, idex_flush=1; stall_cnt increments. This is exactly one bubble; the condition clears naturally on the next cycle.
  3. id_jump: pc_write=1, ifid_flush=1; flush_cnt increments.
  4. Otherwise: all write enables=1, all flushes=0.
- MEM_WAIT:
  - While freeze=1: same outputs as a RUN freeze; wait counter and stall_cnt increment.
  - When the wait counter reaches MAX_WAIT with mem_ready still 0: next state ERROR, mem_timeout is set.
  - When mem_ready=1: the freeze drops that cycle and the RUN priority logic applies to that same cycle; next state RUN; wait counter clears.
  - If mem_req drops while mem_ready=0: treated as completion, same as mem_ready=1.
- ERROR:
  - Full freeze (all enables 0, all flushes 1); mem_timeout=1.
  - Only rst exits this state.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Register 0 is never a hazard source, even when ex_rt==id_rs==0.
- Simultaneous events:
  - A freeze overrides branch, load-use and jump. The frozen EX/ID instructions persist and are resolved once the freeze releases.
  - A rst assertion in any state, including mid-MEM_WAIT, wins in that same cycle.

Decomposition:
- Shared package holds:
  - state encoding localparams (INIT, RUN, MEM_WAIT, ERROR);
  - REG_ZERO = 5'd0;
  - the CNT_W default.
- One sub-module is natural: sat_counter (parameterised width, synchronous rst, inc input, saturating). It is instantiated twice, for stall_cnt and flush_cnt.
- Hazard compare logic stays inline.

Test Plan:
- Reset then INIT: hold rst for 2 cycles, release -> pc_write=0 and all flushes=1 for 4 cycles, then pc_write=1; counters read 0.
- Load-use: ex_memRead=1, ex_rt=8, id_rs=8 for one cycle -> pc_write=0, ifid_write=0, idex_flush=1 for 1 cycle; stall_cnt=1. Repeat with ex_rt=0 -> no stall.
- Branch and jump: ex_branch_taken=1 together with a load-use match and id_jump=1 -> ifid_flush=1, idex_flush=1, pc_write=1; flush_cnt=1; stall_cnt unchanged.
- Memory wait: mem_req=1 with mem_ready=0 for 3 cycles, then 1 -> 3 frozen cycles with memwb_flush=1, release on cycle 4; stall_cnt=3; state returns to RUN.
- Timeout: mem_req=1, mem_ready=0 held for 20 cycles -> mem_timeout rises after the 15th wait cycle and outputs stay frozen. mem_ready=1 afterwards has no effect; rst clears mem_timeout.
- Saturation: with CNT_W=4, force 20 load-use stalls -> stall_cnt holds at 15.
